// File: rtl/serial_byte_tx.sv
// Serial byte transmitter: FIFO-buffered bytes sent as start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1), optional idle gap.
// Latency: a byte pushed into an empty FIFO while idle drives its start bit on the line from the next edge.
// Backpressure: in_ready drops while the FIFO holds DEPTH bytes; no pass-through when full, even on a same-cycle pop.
module serial_byte_tx #(
  parameter int DEPTH      = 4,
  parameter int STOP_BITS  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out,
  output logic                   busy,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]    GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [3:0]    cnt_q, cnt_d;     // data-bit, stop-bit or gap counter depending on state
  logic          out_q, out_d;

  logic          push;
  logic          pop;
  logic          launch;           // frame boundary: start the next byte if one is waiting

  assign in_ready   = (count_q < FULL_CNT);
  assign push       = in_valid && in_ready;
  assign out        = out_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && (cnt_q == STOP_LAST);
  assign fifo_count = count_q;

  // Next-state, shift register, counter and line value; pop happens only when a new frame launches.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    pop     = 1'b0;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        out_d  = 1'b1;
        launch = 1'b1;
      end
      S_START: begin
        out_d   = shreg_q[0];
        shreg_d = shreg_q >> 1;
        cnt_d   = 4'd0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == 4'd7) begin
          out_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_STOP;
        end else begin
          out_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_STOP: begin
        out_d = 1'b1;
        if (cnt_q == STOP_LAST) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = 4'd0;
            state_d = S_GAP;
          end else begin
            launch = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        out_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          launch = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        out_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // Shared exit path of IDLE/STOP/GAP: back-to-back start if the FIFO has data, else rest idle.
    if (launch) begin
      if (count_q != '0) begin
        pop     = 1'b1;
        shreg_d = mem_q[rd_ptr_q];
        out_d   = 1'b0;
        state_d = S_START;
      end else begin
        out_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  // FSM, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= 8'd0;
      cnt_q   <= 4'd0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_byte;
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Testbench for serial_byte_tx: vector tables, hand-written corner sequences and a randomized line-decoding model.
// Two instances: default parameters, and STOP_BITS=2 / GAP_CYCLES=3.
// Inputs driven #1 after the rising edge, outputs sampled there too.
module tb_serial_byte_tx;

  logic       clk;
  logic       rst_a, vld_a, rdy_a, out_a, busy_a, fd_a;
  logic [7:0] byte_a;
  logic [2:0] cnt_a;
  logic       rst_b, vld_b, rdy_b, out_b, busy_b, fd_b;
  logic [7:0] byte_b;
  logic [2:0] cnt_b;

  serial_byte_tx #(.DEPTH(4), .STOP_BITS(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(rst_a), .in_byte(byte_a), .in_valid(vld_a), .in_ready(rdy_a),
    .out(out_a), .busy(busy_a), .frame_done(fd_a), .fifo_count(cnt_a)
  );

  serial_byte_tx #(.DEPTH(4), .STOP_BITS(2), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst_b), .in_byte(byte_b), .in_valid(vld_b), .in_ready(rdy_b),
    .out(out_b), .busy(busy_b), .frame_done(fd_b), .fifo_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         vld;
    logic [7:0] dat;
    bit         e_out;
    bit         e_busy;
    bit         e_fd;
    int         e_cnt;
    bit         e_rdy;
  } vec_t;

  vec_t       vt[$];
  int         checks = 0;
  int         errors = 0;
  // Reference model for dut_a: bytes accepted, starts seen on the line, frame decoder position.
  logic [7:0] exp_q[$];
  int         m_pushes = 0;
  int         m_starts = 0;
  int         rx_pos = -1;
  int         frames = 0;
  logic [7:0] rx_byte;

  logic [7:0] lst [6];
  logic [7:0] pat;
  int         f0, idx, pre, max_cnt, sent, guard;
  bit         saw_block;
  bit         e_out;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit v, logic [7:0] d, bit o, bit b, bit f, int c, bit r);
    vec_t t;
    t.vld = v; t.dat = d; t.e_out = o; t.e_busy = b; t.e_fd = f; t.e_cnt = c; t.e_rdy = r;
    return t;
  endfunction

  // One clock of dut_a, with the model tracking occupancy and decoding frames off the line.
  task automatic step_a();
    int mc;
    bit exp_rdy;
    bit in_frame;
    mc      = m_pushes - m_starts;
    exp_rdy = (mc < 4);
    if (!rst_a) begin
      chk("in_ready", int'(rdy_a), int'(exp_rdy));
      if (vld_a && exp_rdy) begin
        exp_q.push_back(byte_a);
        m_pushes++;
      end
    end
    @(posedge clk);
    #1;
    if (rst_a) begin
      exp_q.delete();
      m_pushes = 0;
      m_starts = 0;
      rx_pos   = -1;
    end else begin
      in_frame = 1'b0;
      if (rx_pos < 0) begin
        chk("frame_done_outside", int'(fd_a), 0);
        if (out_a == 1'b0) begin
          rx_pos = 0;
          m_starts++;
          in_frame = 1'b1;
        end
      end else begin
        in_frame = 1'b1;
        rx_pos++;
        if (rx_pos <= 8) begin
          rx_byte[rx_pos-1] = out_a;
          chk("frame_done_data", int'(fd_a), 0);
        end else begin
          chk("stop_bit", int'(out_a), 1);
          chk("frame_done_stop", int'(fd_a), 1);
          chk("rx_expected_byte_pending", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("rx_byte", int'(rx_byte), int'(exp_q.pop_front()));
          rx_pos = -1;
          frames++;
        end
      end
      chk("busy", int'(busy_a), int'(in_frame));
      chk("fifo_count", int'(cnt_a), m_pushes - m_starts);
    end
  endtask

  initial begin
    rst_a = 1'b1; vld_a = 1'b0; byte_a = 8'h00;
    rst_b = 1'b1; vld_b = 1'b0; byte_b = 8'h00;
    lst[0] = 8'h11; lst[1] = 8'h22; lst[2] = 8'h33;
    lst[3] = 8'h44; lst[4] = 8'h55; lst[5] = 8'h66;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_a", int'(out_a), 1);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_fd_a", int'(fd_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_rdy_a", int'(rdy_a), 1);
    chk("rst_out_b", int'(out_b), 1);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Vector table: single 0xA5 frame, then 0x00/0xFF back-to-back.
    pat = 8'hA5;
    vt.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b1));
    for (int i = 0; i < 8; i++) vt.push_back(mk(1'b0, 8'h00, pat[i], 1'b1, 1'b0, 0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1));
    vt.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1));
    vt.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1, 1'b1));
    for (int i = 0; i < 8; i++) vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b1));
    for (int i = 0; i < 8; i++) vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0, 1'b1));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1));

    foreach (vt[i]) begin
      vld_a  = vt[i].vld;
      byte_a = vt[i].dat;
      step_a();
      chk($sformatf("vec%0d_out", i), int'(out_a), int'(vt[i].e_out));
      chk($sformatf("vec%0d_busy", i), int'(busy_a), int'(vt[i].e_busy));
      chk($sformatf("vec%0d_frame_done", i), int'(fd_a), int'(vt[i].e_fd));
      chk($sformatf("vec%0d_count", i), int'(cnt_a), vt[i].e_cnt);
      chk($sformatf("vec%0d_ready", i), int'(rdy_a), int'(vt[i].e_rdy));
    end
    vld_a = 1'b0;

    // FIFO full: hold valid with six bytes from idle.
    f0 = frames; idx = 0; saw_block = 1'b0; max_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      vld_a = (idx < 6);
      if (idx < 6) byte_a = lst[idx];
      if (vld_a && (m_pushes - m_starts) >= 4) saw_block = 1'b1;
      pre = m_pushes;
      step_a();
      if (m_pushes != pre) idx++;
      if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
    end
    vld_a = 1'b0;
    chk("full_blocked_seen", int'(saw_block), 1);
    chk("full_max_count", max_cnt, 4);
    chk("full_frames", frames - f0, 6);
    chk("full_queue_drained", exp_q.size(), 0);

    // Reset mid-frame: 0x81, reset while data bit 3 is on the line.
    vld_a = 1'b1; byte_a = 8'h81;
    step_a();
    vld_a = 1'b0;
    repeat (5) step_a();
    chk("mid_bit3", int'(out_a), 0);
    rst_a = 1'b1;
    step_a();
    rst_a = 1'b0;
    chk("mid_rst_out", int'(out_a), 1);
    chk("mid_rst_cnt", int'(cnt_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_rdy", int'(rdy_a), 1);
    f0 = frames;
    vld_a = 1'b1; byte_a = 8'h7E;
    step_a();
    vld_a = 1'b0;
    repeat (14) step_a();
    chk("mid_after_frames", frames - f0, 1);
    chk("mid_after_queue", exp_q.size(), 0);

    // Randomized: 256 random bytes with random valid gaps, decoded and checked by the model.
    f0 = frames; sent = 0; guard = 0;
    while ((sent < 256 || (frames - f0) < 256) && guard < 20000) begin
      vld_a  = (sent < 256) && ($urandom_range(0, 3) != 0);
      byte_a = 8'($urandom_range(0, 255));
      pre = m_pushes;
      step_a();
      if (m_pushes != pre) sent++;
      guard++;
    end
    vld_a = 1'b0;
    chk("rand_sent", sent, 256);
    chk("rand_frames", frames - f0, 256);
    chk("rand_queue_drained", exp_q.size(), 0);

    // STOP_BITS=2, GAP_CYCLES=3: 0x3C twice, 14-cycle frame period.
    pat = 8'h3C;
    vld_b = 1'b1; byte_b = 8'h3C;
    @(posedge clk);
    #1;
    for (int k = 0; k <= 28; k++) begin
      @(posedge clk);
      #1;
      vld_b = 1'b0;
      if (k >= 28) e_out = 1'b1;
      else if ((k % 14) == 0) e_out = 1'b0;
      else if ((k % 14) <= 8) e_out = pat[(k % 14) - 1];
      else e_out = 1'b1;
      chk($sformatf("b_out_k%0d", k), int'(out_b), int'(e_out));
      chk($sformatf("b_fd_k%0d", k), int'(fd_b), int'(k == 10 || k == 24));
      chk($sformatf("b_busy_k%0d", k), int'(busy_b), int'(k < 28));
      chk($sformatf("b_cnt_k%0d", k), int'(cnt_b), (k < 14) ? 1 : 0);
    end
    chk("b_ready_end", int'(rdy_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_byte_tx.md
Name: serial_byte_tx

Overview:
Transmit-side companion to the serial byte receiver. Accepts bytes over a valid/ready interface into a small FIFO. Serializes each byte onto a single line, one bit per clk: start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1). Line idles high. Output is directly consumable by the receiver FSM. Back-to-back frames are supported.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
STOP_BITS, 1, stop-bit cycles per frame; 1..4
GAP_CYCLES, 0, extra idle-high cycles forced after each frame; 0..15

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  reset, synchronous, active-high
in_byte  input  8  byte to transmit
in_valid  input  1  in_byte valid
in_ready  output  1  FIFO can accept; combinational, = (fifo_count < DEPTH)
out  output  1  serial line, registered
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse on the final stop-bit cycle
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset state (applied on the edge where reset=1, overriding all else):
  - out=1, state=IDLE, FIFO emptied (fifo_count=0, pointers 0), shift reg 0, bit counter 0.
  - busy=0, frame_done=0, in_ready=1.
- Reset mid-frame aborts the frame; the line returns high on the next cycle. No partial bits resume.
- Push: occurs on an edge where in_valid && in_ready. Writes in_byte at the write pointer; the pointer wraps modulo DEPTH.
- When full, in_ready=0 and in_valid is ignored. There is no pass-through when full, even if a pop happens in the same cycle.
- Pop: occurs on an edge where the FSM leaves IDLE, STOP or GAP toward START with fifo_count != 0. Loads the head into the 8-bit shift register.
- Simultaneous push and pop: fifo_count unchanged, both pointers advance.
- FSM states:
  - IDLE: out=1.
    - fifo_count != 0 -> pop, out<=0, go to START.
  - START: one cycle, out=0.
    - Next edge: out<=shreg[0], shreg>>=1, bitcnt<=0, go to DATA.
  - DATA: out holds the current data bit.
    - Each edge: bitcnt+1, out<=shreg[0], shift.
    - After the 8th data-bit cycle (bitcnt==7): out<=1, stopcnt<=0, go to STOP.
  - STOP: out=1, lasts STOP_BITS cycles. frame_done=1 during the last stop cycle.
    - On exit, GAP_CYCLES>0 -> GAP.
    - Otherwise fifo_count != 0 -> pop, out<=0, START (back-to-back).
    - Otherwise -> IDLE.
  - GAP: out=1 for GAP_CYCLES cycles.
    - Then fifo_count != 0 -> pop, START; else IDLE.
- Frame length: 1+8+STOP_BITS cycles. Frame period with continuous data: 9+STOP_BITS+GAP_CYCLES.
- Latency: byte pushed at edge N into an empty FIFO while IDLE; start bit is driven on out from edge N+1.
- A push during the cycle the FSM checks fifo_count is not seen until the following edge (registered count).
- Bytes are transmitted in push order; no drops or duplicates.
- out is glitch-free (flop output). frame_done and busy decode from registered state/counters.

Test Plan:
- Single byte: reset, push 0xA5 once.
  - out from edge N+1: 0,1,0,1,0,0,1,0,1,1, then idle 1.
  - frame_done high exactly on the stop cycle.
  - busy high for 10 cycles.
- Back-to-back: push 0x00 then 0xFF (STOP_BITS=1, GAP_CYCLES=0).
  - Expect 0,00000000,1,0,11111111,1 with no idle cycle between frames.
  - Two frame_done pulses, 10 cycles apart.
- FIFO full: hold in_valid with 0x11,0x22,0x33,0x44,0x55,0x66 from idle.
  - in_ready drops when fifo_count reaches 4.
  - 0x55 is accepted only after a pop.
  - All six bytes appear in order.
  - fifo_count never exceeds 4.
- Parameters: STOP_BITS=2, GAP_CYCLES=3, push 0x3C twice.
  - Each frame has 2 stop cycles plus 3 gap cycles (5 high cycles between data bit 7 and the next start bit).
  - Period 14 cycles.
- Reset mid-frame: push 0x81, assert reset during data bit 3 for 1 cycle.
  - out=1 the next cycle, fifo_count=0, busy=0, in_ready=1.
  - A subsequent push of 0x7E transmits cleanly.
- Loopback: connect out to the receiver's in and send 256 random bytes.
  - Every receiver done pulse carries the matching out_byte.
  - Receiver never enters its error state.
